mem_port_arbiter: RTL and testbench

//  Shares the single-port, 1-cycle-registered-read program/data memory between two masters.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single-port memory with a one-cycle registered read between two
// masters: master 0 (CPU fetch/load) and master 1 (debug/program loader).
// One access is in flight at a time; the FSM walks IDLE -> ISSUE -> RESP.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin tie breaking.
// Without it, master 0 wins every simultaneous request.
//
// Handshake: a master raises req with we/addr/wdata stable and holds them
// until gnt. gnt is a one-cycle pulse in the cycle the access is presented to
// the memory. Requests are sampled only while the arbiter is idle, so a req
// still high in the cycle after gnt is arbitrated again as a new access. Read
// data returns as a one-cycle rvalid pulse with rdata. There is no
// backpressure on the return, and rdata holds until the next return.
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q,
  output logic          arb_busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  logic   cur_master;  // master owning the access in flight
  logic   cur_we;      // access in flight is a write
  logic   pick;        // winner when arbitrating in IDLE
`ifdef MEM_ARB_RR_EN
  logic   last_grant;  // master granted most recently
`endif

  // Select the winning master from the current requests.
  always_comb begin
    pick = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (m0_req && m1_req) pick = ~last_grant;
    else                  pick = m1_req;
`else
    pick = ~m0_req;
`endif
  end

  // Access sequencer: arbitrate, present the access for one cycle, return read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_master <= 1'b0;
      cur_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (m0_req || m1_req) begin
            cur_master <= pick;
            if (pick) begin
              mem_addr <= m1_addr;
              mem_data <= m1_wdata;
              mem_we   <= m1_we;
              cur_we   <= m1_we;
              m1_gnt   <= 1'b1;
            end else begin
              mem_addr <= m0_addr;
              mem_data <= m0_wdata;
              mem_we   <= m0_we;
              cur_we   <= m0_we;
              m0_gnt   <= 1'b1;
            end
`ifdef MEM_ARB_RR_EN
            last_grant <= pick;
`endif
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Memory samples addr/data/we at the edge ending this cycle.
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          mem_we <= 1'b0;
          state  <= cur_we ? IDLE : RESP;
        end
        RESP: begin
          if (cur_master) begin
            m1_rdata  <= mem_q;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= mem_q;
            m0_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb_busy  = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a memory fixture, a transaction-level
// reference model compared every cycle, and directed scenarios with
// hand-computed literal expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic [DW-1:0] mem_q;
  logic          arb_busy;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .arb_busy(arb_busy), .dbg_state(dbg_state)
  );

  // ---------------- memory fixture (registered read) ----------------
  logic [DW-1:0] fix_mem [0:65535];
  initial mem_q = '0;
  always @(posedge clk) begin
    mem_q <= fix_mem[mem_addr];
    if (mem_we) fix_mem[mem_addr] = mem_data;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction level: a grant decided from the requests seen in an idle
  // cycle N shows gnt in N+1, keeps the arbiter busy through N+1 (write) or
  // N+2 (read), and returns read data in N+3.
  logic [DW-1:0] ref_mem [0:65535];
  int            free_at = 0;
  int            ret_c_q[$];
  bit            ret_w_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_g0, exp_g1, exp_rv0, exp_rv1, exp_we, exp_busy;
  logic [DW-1:0] exp_rd0, exp_rd1, exp_data;
  logic [AW-1:0] exp_addr;
  bit            mdl_w, mdl_we;
  logic [AW-1:0] mdl_a;
  logic [DW-1:0] mdl_d;
`ifdef MEM_ARB_RR_EN
  bit            last_w = 1'b1;
`endif

  always @(posedge clk) begin
    cyc = cyc + 1;
    exp_g0 = 1'b0; exp_g1 = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_we = 1'b0;
    if (reset) begin
      free_at = cyc;
      ret_c_q.delete(); ret_w_q.delete(); exp_q.delete();
      exp_rd0 = '0; exp_rd1 = '0; exp_addr = '0; exp_data = '0; exp_busy = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_w = 1'b1;
`endif
    end else begin
      if (ret_c_q.size() > 0 && ret_c_q[0] == cyc) begin
        void'(ret_c_q.pop_front());
        mdl_w = ret_w_q.pop_front();
        mdl_d = exp_q.pop_front();
        if (mdl_w) begin exp_rv1 = 1'b1; exp_rd1 = mdl_d; end
        else       begin exp_rv0 = 1'b1; exp_rd0 = mdl_d; end
      end
      if ((cyc - 1) >= free_at && (m0_req || m1_req)) begin
        if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
          mdl_w = ~last_w;
`else
          mdl_w = 1'b0;
`endif
        end else begin
          mdl_w = m1_req;
        end
`ifdef MEM_ARB_RR_EN
        last_w = mdl_w;
`endif
        mdl_we = mdl_w ? m1_we : m0_we;
        mdl_a  = mdl_w ? m1_addr : m0_addr;
        mdl_d  = mdl_w ? m1_wdata : m0_wdata;
        exp_addr = mdl_a; exp_data = mdl_d; exp_we = mdl_we;
        if (mdl_w) exp_g1 = 1'b1; else exp_g0 = 1'b1;
        if (mdl_we) begin
          ref_mem[mdl_a] = mdl_d;
          free_at = cyc + 1;
        end else begin
          free_at = cyc + 2;
          ret_c_q.push_back(cyc + 2);
          ret_w_q.push_back(mdl_w);
          exp_q.push_back(ref_mem[mdl_a]);
        end
      end
      exp_busy = (cyc < free_at);
    end
  end

  // ---------------- compare process and monitors ----------------
  int g0_cnt = 0, g1_cnt = 0, both_cnt = 0, we_cnt = 0, rv1_cnt = 0;
  bit gnt_seq[$];
  int rv0_cyc[$];
  logic [DW-1:0] rv0_dat[$];

  always @(negedge clk) begin
    if (reset) begin
      check("rst_outputs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, arb_busy}, 32'd0);
      check("rst_data", {m0_rdata, m1_rdata}, 32'd0);
      check("rst_mem_addr_data", {mem_addr, mem_data}, 32'd0);
    end else begin
      check("m0_gnt", m0_gnt, exp_g0);
      check("m1_gnt", m1_gnt, exp_g1);
      check("m0_rvalid", m0_rvalid, exp_rv0);
      check("m1_rvalid", m1_rvalid, exp_rv1);
      check("m0_rdata", m0_rdata, exp_rd0);
      check("m1_rdata", m1_rdata, exp_rd1);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_data", mem_data, exp_data);
      check("mem_we", mem_we, exp_we);
      check("arb_busy", arb_busy, exp_busy);
      check("dbg_state_idle", dbg_state == 2'd0, !exp_busy);
    end
    if (m0_gnt) begin g0_cnt++; gnt_seq.push_back(1'b0); end
    if (m1_gnt) begin g1_cnt++; gnt_seq.push_back(1'b1); end
    if (m0_gnt && m1_gnt) both_cnt++;
    if (mem_we) we_cnt++;
    if (m1_rvalid) rv1_cnt++;
    if (m0_rvalid) begin rv0_cyc.push_back(cyc); rv0_dat.push_back(m0_rdata); end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input int m, input bit req, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  // Wait up to 10 cycles for the master's gnt; lat = cycles waited or -1.
  task automatic wait_gnt(input int m, output int lat);
    bit seen;
    lat = -1; seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(posedge clk); #1;
      if ((m == 0) ? m0_gnt : m1_gnt) begin lat = i; seen = 1'b1; end
    end
  endtask

  // One access from cycle N; latencies are counted from N.
  task automatic single_access(input int m, input bit we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, output int g_lat,
                               output int r_lat, output logic [DW-1:0] rd);
    bit seen;
    r_lat = -1; rd = '0; seen = 1'b0;
    set_req(m, 1'b1, we, a, d);
    wait_gnt(m, g_lat);
    set_req(m, 1'b0, 1'b0, '0, '0);
    if (!we && g_lat > 0) begin
      for (int j = g_lat + 1; j <= g_lat + 10 && !seen; j++) begin
        @(posedge clk); #1;
        if ((m == 0) ? m0_rvalid : m1_rvalid) begin
          r_lat = j; rd = (m == 0) ? m0_rdata : m1_rdata; seen = 1'b1;
        end
      end
    end
  endtask

  // ---------------- directed scenarios ----------------
  int g_lat, r_lat, base_a, base_b, base_c;
  logic [DW-1:0] rd;

  initial begin
    for (int i = 0; i < 65536; i++) begin fix_mem[i] = '0; ref_mem[i] = '0; end
    fix_mem[1] = 16'h2003; ref_mem[1] = 16'h2003;
    fix_mem[2] = 16'hFFFF; ref_mem[2] = 16'hFFFF;
    fix_mem[3] = 16'h3333; ref_mem[3] = 16'h3333;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", arb_busy, 1'b0);
    check("reset_mem_addr", mem_addr, 16'h0000);

    // T1: m0 read of addr 2
    base_a = g1_cnt + rv1_cnt;
    single_access(0, 1'b0, 16'h0002, 16'h0000, g_lat, r_lat, rd);
    check("t1_gnt_latency", g_lat, 1);
    check("t1_rvalid_latency", r_lat, 3);
    check("t1_rdata", rd, 16'hFFFF);
    check("t1_m1_quiet", g1_cnt + rv1_cnt - base_a, 0);
    idle(2);

    // T2: m1 writes 0x1005 to addr 0, m0 reads it back
    base_a = we_cnt;
    single_access(1, 1'b1, 16'h0000, 16'h1005, g_lat, r_lat, rd);
    check("t2_write_gnt_latency", g_lat, 1);
    idle(2);
    check("t2_we_cycles", we_cnt - base_a, 1);
    single_access(0, 1'b0, 16'h0000, 16'h0000, g_lat, r_lat, rd);
    check("t2_readback", rd, 16'h1005);
    // m1 read so that master 1 holds the most recent grant going into T3
    single_access(1, 1'b0, 16'h0003, 16'h0000, g_lat, r_lat, rd);
    check("t2_m1_read", rd, 16'h3333);
    idle(2);

    // T3: both masters hold write requests for 8 cycles
    base_a = g0_cnt; base_b = g1_cnt; base_c = both_cnt;
    gnt_seq.delete();
    set_req(0, 1'b1, 1'b1, 16'h0010, 16'hAAAA);
    set_req(1, 1'b1, 1'b1, 16'h0011, 16'hBBBB);
    idle(8);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    idle(2);
    check("t3_grant_count", gnt_seq.size(), 4);
    check("t3_no_double_gnt", both_cnt - base_c, 0);
`ifdef MEM_ARB_RR_EN
    check("t3_m0_grants", g0_cnt - base_a, 2);
    check("t3_m1_grants", g1_cnt - base_b, 2);
    if (gnt_seq.size() >= 4) begin
      check("t3_seq0", gnt_seq[0], 1'b0);
      check("t3_seq1", gnt_seq[1], 1'b1);
      check("t3_seq2", gnt_seq[2], 1'b0);
      check("t3_seq3", gnt_seq[3], 1'b1);
    end
`else
    check("t3_m0_grants", g0_cnt - base_a, 4);
    check("t3_m1_grants", g1_cnt - base_b, 0);
`endif

    // T4: reset while an m1 read is in RESP
    base_a = rv1_cnt;
    set_req(1, 1'b1, 1'b0, 16'h0003, 16'h0000);
    wait_gnt(1, g_lat);
    check("t4_gnt_latency", g_lat, 1);
    set_req(1, 1'b0, 1'b0, '0, '0);
    idle(1);
    check("t4_busy_in_resp", arb_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("t4_reset_flags", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, arb_busy}, 32'd0);
    check("t4_reset_m1_rdata", m1_rdata, 16'h0000);
    check("t4_reset_mem_addr", mem_addr, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    check("t4_no_m1_rvalid", rv1_cnt - base_a, 0);
    single_access(0, 1'b0, 16'h0001, 16'h0000, g_lat, r_lat, rd);
    check("t4_after_reset_gnt", g_lat, 1);
    check("t4_after_reset_rdata", rd, 16'h2003);
    idle(2);

    // T5: back-to-back m0 reads of addr 0 then addr 1
    rv0_cyc.delete(); rv0_dat.delete();
    set_req(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    wait_gnt(0, g_lat);
    check("t5_first_gnt", g_lat, 1);
    set_req(0, 1'b1, 1'b0, 16'h0001, 16'h0000);
    wait_gnt(0, g_lat);
    check("t5_second_gnt", g_lat, 3);
    set_req(0, 1'b0, 1'b0, '0, '0);
    idle(5);
    check("t5_rvalid_count", rv0_cyc.size(), 2);
    if (rv0_cyc.size() >= 2) begin
      check("t5_rvalid_spacing", rv0_cyc[1] - rv0_cyc[0], 3);
      check("t5_data0", rv0_dat[0], 16'h1005);
      check("t5_data1", rv0_dat[1], 16'h2003);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
